// File: rtl/pci_master_pkg.sv
// PCI bus command codes and scheduler FSM encoding shared by the command splitter.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package pci_master_pkg;

  localparam logic [3:0] CMD_MR  = 4'h6;
  localparam logic [3:0] CMD_MW  = 4'h7;
  localparam logic [3:0] CMD_MRM = 4'hC;
  localparam logic [3:0] CMD_MRL = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

endpackage

// File: rtl/pci_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr (wrapping), as one-hot grant plus index.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module pci_rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Scan channels starting at the pointer; the first hit wins.
  always_comb begin
    int c;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = PW'(c);
      end
    end
  end

endmodule

// File: rtl/pci_master_cmd_split.sv
// Arbitrates read/write command channels and splits each burst into PCI sub-bursts with bus command.
// Latency: accept at N -> first sub-burst valid at N+2; each later sub-burst 2 cycles after the previous handshake.
// Backpressure: sub-burst held stable while out_cmd_ready is low; no channel is granted until the last sub-burst is taken.
module pci_master_cmd_split
  import pci_master_pkg::*;
#(
  parameter int             NCH         = 2,
  parameter logic [NCH-1:0] CH_WRITE    = 2'b01,
  parameter int             ID_W        = 4,
  parameter int             ADDR_W      = 64,
  parameter int             LEN_W       = 8,
  parameter int             MAX_BURST   = 64,
  parameter int             BOUND_SHIFT = 12,
  parameter int             CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            cacheline_size,
  input  logic [NCH*ID_W-1:0]   in_cmd_id,
  input  logic [NCH*ADDR_W-1:0] in_cmd_addr,
  input  logic [NCH*LEN_W-1:0]  in_cmd_len,
  input  logic [NCH-1:0]        in_cmd_valid,
  output logic [NCH-1:0]        in_cmd_ready,
  output logic [CHW-1:0]        out_cmd_ch,
  output logic [ID_W-1:0]       out_cmd_id,
  output logic [ADDR_W-1:0]     out_cmd_addr,
  output logic [LEN_W-1:0]      out_cmd_len,
  output logic [3:0]            out_cmd_cbe,
  output logic                  out_cmd_dac,
  output logic                  out_cmd_last,
  output logic                  out_cmd_valid,
  input  logic                  out_cmd_ready
);

  localparam int RW = LEN_W + 1;
  localparam int CW = (RW > BOUND_SHIFT + 1) ? RW : BOUND_SHIFT + 1;

  state_e             state_q, state_d;
  logic [CHW-1:0]     ptr_q, ptr_d, ch_q, ch_d;
  logic               wr_q, wr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [RW-1:0]      rem_q, rem_d, beats_q, beats_d;
  logic [CHW-1:0]     o_ch_q, o_ch_d;
  logic [ID_W-1:0]    o_id_q, o_id_d;
  logic [ADDR_W-1:0]  o_addr_q, o_addr_d;
  logic [LEN_W-1:0]   o_len_q, o_len_d;
  logic [3:0]         o_cbe_q, o_cbe_d;
  logic               o_dac_q, o_dac_d, o_last_q, o_last_d;

  logic [NCH-1:0]     gnt;
  logic [CHW-1:0]     gnt_idx;
  logic               gnt_any;

  logic [BOUND_SHIFT:0] room_bytes;
  logic [CW-1:0]        room_w, beats_w;
  logic [RW-1:0]        beats;
  logic [ADDR_W-3:0]    dw_mod;
  logic [3:0]           cbe;
  logic                 dac_calc;

  pci_rr_arbiter #(.N(NCH), .PW(CHW)) u_arb (
    .req (in_cmd_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // Only IDLE grants; reset forces every output low including the ready strobe.
  assign in_cmd_ready = (state_q == ST_IDLE && !rst) ? gnt : '0;

  if (ADDR_W > 32) begin : g_dac
    assign dac_calc = |addr_q[ADDR_W-1:32];
  end else begin : g_no_dac
    assign dac_calc = 1'b0;
  end

  // Sub-burst size (remaining, max burst, room to boundary) and the PCI command for it.
  always_comb begin
    room_bytes = {1'b1, {BOUND_SHIFT{1'b0}}} - {1'b0, addr_q[BOUND_SHIFT-1:0]};
    room_w     = CW'(room_bytes >> 2);
    beats_w    = CW'(rem_q);
    if (CW'(MAX_BURST) < beats_w) beats_w = CW'(MAX_BURST);
    if (room_w < beats_w)         beats_w = room_w;
    beats  = RW'(beats_w);
    dw_mod = '0;
    if (cacheline_size != 8'd0)
      dw_mod = addr_q[ADDR_W-1:2] % {{(ADDR_W-10){1'b0}}, cacheline_size};
    if (wr_q)
      cbe = CMD_MW;
    else if (cacheline_size != 8'd0 && 32'(beats_w) >= 32'(cacheline_size) && dw_mod == '0)
      cbe = CMD_MRM;
    else if (beats > RW'(1))
      cbe = CMD_MRL;
    else
      cbe = CMD_MR;
  end

  // Next-state and datapath updates for the IDLE -> CALC -> ISSUE sequence.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ch_d     = ch_q;
    wr_d     = wr_q;
    id_d     = id_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    beats_d  = beats_q;
    o_ch_d   = o_ch_q;
    o_id_d   = o_id_q;
    o_addr_d = o_addr_q;
    o_len_d  = o_len_q;
    o_cbe_d  = o_cbe_q;
    o_dac_d  = o_dac_q;
    o_last_d = o_last_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          ch_d   = gnt_idx;
          wr_d   = CH_WRITE[gnt_idx];
          id_d   = in_cmd_id[gnt_idx*ID_W +: ID_W];
          addr_d = {in_cmd_addr[gnt_idx*ADDR_W+2 +: ADDR_W-2], 2'b00};
          rem_d  = RW'(in_cmd_len[gnt_idx*LEN_W +: LEN_W]) + RW'(1);
          ptr_d  = (gnt_idx == CHW'(NCH-1)) ? '0 : gnt_idx + CHW'(1);
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        o_ch_d   = ch_q;
        o_id_d   = id_q;
        o_addr_d = addr_q;
        o_len_d  = LEN_W'(beats - RW'(1));
        o_cbe_d  = cbe;
        o_dac_d  = dac_calc;
        o_last_d = (beats == rem_q);
        beats_d  = beats;
        state_d  = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (out_cmd_ready) begin
          addr_d  = addr_q + (ADDR_W'(beats_q) << 2);
          rem_d   = rem_q - beats_q;
          state_d = o_last_q ? ST_IDLE : ST_CALC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      ch_q     <= '0;
      wr_q     <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
      beats_q  <= '0;
      o_ch_q   <= '0;
      o_id_q   <= '0;
      o_addr_q <= '0;
      o_len_q  <= '0;
      o_cbe_q  <= '0;
      o_dac_q  <= 1'b0;
      o_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ch_q     <= ch_d;
      wr_q     <= wr_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      beats_q  <= beats_d;
      o_ch_q   <= o_ch_d;
      o_id_q   <= o_id_d;
      o_addr_q <= o_addr_d;
      o_len_q  <= o_len_d;
      o_cbe_q  <= o_cbe_d;
      o_dac_q  <= o_dac_d;
      o_last_q <= o_last_d;
    end
  end

  assign out_cmd_ch    = o_ch_q;
  assign out_cmd_id    = o_id_q;
  assign out_cmd_addr  = o_addr_q;
  assign out_cmd_len   = o_len_q;
  assign out_cmd_cbe   = o_cbe_q;
  assign out_cmd_dac   = o_dac_q;
  assign out_cmd_last  = o_last_q;
  assign out_cmd_valid = (state_q == ST_ISSUE);

endmodule

// File: tb/tb_pci_master_cmd_split.sv
// Scoreboard bench: channel 0 writes, channel 1 reads; expected sub-bursts come from a splitting model.
// Latency: checks valid timing (2 cycles after accept / handshake) every cycle.
// Backpressure: random and held-low out_cmd_ready, with field stability checked while stalled.
module tb_pci_master_cmd_split;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
    int          gap;
  } pkt_t;

  typedef struct {
    logic        ch;
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [3:0]  cbe;
    logic        dac;
    logic        last;
  } sub_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   cl_size;
  logic [7:0]   in_id;
  logic [127:0] in_addr;
  logic [15:0]  in_len;
  logic [1:0]   in_vld, in_rdy;
  logic         out_ch;
  logic [3:0]   out_id, out_cbe;
  logic [63:0]  out_addr;
  logic [7:0]   out_len;
  logic         out_dac, out_last, out_vld, out_rdy;

  pci_master_cmd_split #(
    .NCH(2), .CH_WRITE(2'b01), .ID_W(4), .ADDR_W(64), .LEN_W(8),
    .MAX_BURST(64), .BOUND_SHIFT(12)
  ) dut (
    .clk(clk), .rst(rst), .cacheline_size(cl_size),
    .in_cmd_id(in_id), .in_cmd_addr(in_addr), .in_cmd_len(in_len),
    .in_cmd_valid(in_vld), .in_cmd_ready(in_rdy),
    .out_cmd_ch(out_ch), .out_cmd_id(out_id), .out_cmd_addr(out_addr),
    .out_cmd_len(out_len), .out_cmd_cbe(out_cbe), .out_cmd_dac(out_dac),
    .out_cmd_last(out_last), .out_cmd_valid(out_vld), .out_cmd_ready(out_rdy)
  );

  always #5 clk = ~clk;

  // Owned by the monitor
  int   checks = 0, errors = 0, cyc = 0, next_vld = 0, hs_cnt = 0, mptr = 0;
  bit   busy = 0, have_snap = 0;
  logic [1:0] acc = 2'b00;
  logic [82:0] snap;
  sub_t exp_q[$];
  // Owned by the stimulus process
  int   timeouts = 0;
  bit   done = 0, rdy_rand = 0;
  pkt_t cq0[$], cq1[$];
  int   gapc[2], gap_after[2];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      if (errors < 30) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: split by remaining beats, 64-beat cap and 4 KiB boundaries, then pick the bus command.
  task automatic push_subs(input int k, input logic [3:0] id, input logic [63:0] addr,
                           input logic [7:0] len, input logic [7:0] clv);
    logic [63:0] a, dw;
    int rem, room, b;
    sub_t s;
    a = addr & ~64'h3;
    rem = int'(len) + 1;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 4;
      b = rem;
      if (b > 64) b = 64;
      if (b > room) b = room;
      dw = a >> 2;
      s.ch = k[0];
      s.id = id;
      s.addr = a;
      s.len = 8'(b - 1);
      if (k == 0) s.cbe = 4'h7;
      else if (clv != 0 && b >= int'(clv) && (dw % 64'(clv)) == 0) s.cbe = 4'hC;
      else if (b > 1) s.cbe = 4'hE;
      else s.cbe = 4'h6;
      s.dac = (a[63:32] != 0);
      s.last = (b == rem);
      exp_q.push_back(s);
      a = a + 64'(b * 4);
      rem = rem - b;
    end
  endtask

  // Monitor: arbitration prediction, valid timing, stability and scoreboard compare.
  always @(negedge clk) begin
    logic [1:0] exp_rdy;
    logic [82:0] cur;
    sub_t e;
    int c, k;
    cyc++;
    acc = in_rdy;
    cur = {out_ch, out_id, out_addr, out_len, out_cbe, out_dac, out_last};
    if (rst) begin
      chk(in_rdy == 2'b00, "rst_in_ready", 64'(in_rdy), 0);
      chk(out_vld == 1'b0, "rst_out_valid", 64'(out_vld), 0);
      chk(cur == '0, "rst_out_fields", cur[63:0], 0);
      exp_q.delete();
      busy = 0; mptr = 0; have_snap = 0;
    end else begin
      exp_rdy = 2'b00;
      if (!busy) begin
        for (int i = 0; i < 2; i++) begin
          c = (mptr + i) % 2;
          if (exp_rdy == 2'b00 && in_vld[c]) exp_rdy[c] = 1'b1;
        end
      end
      chk(in_rdy == exp_rdy, "in_ready", 64'(in_rdy), 64'(exp_rdy));
      if (exp_rdy != 2'b00) begin
        k = exp_rdy[1] ? 1 : 0;
        push_subs(k, in_id[k*4 +: 4], in_addr[k*64 +: 64], in_len[k*8 +: 8], cl_size);
        busy = 1; mptr = (k + 1) % 2; next_vld = cyc + 2;
      end
      chk(out_vld == (exp_q.size() > 0 && cyc >= next_vld), "out_valid", 64'(out_vld),
          64'(exp_q.size() > 0 && cyc >= next_vld));
      if (out_vld && have_snap) chk(cur == snap, "stable_fields", cur[63:0], snap[63:0]);
      if (out_vld && out_rdy && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(out_ch == e.ch, "ch", 64'(out_ch), 64'(e.ch));
        chk(out_id == e.id, "id", 64'(out_id), 64'(e.id));
        chk(out_addr == e.addr, "addr", out_addr, e.addr);
        chk(out_len == e.len, "len", 64'(out_len), 64'(e.len));
        chk(out_cbe == e.cbe, "cbe", 64'(out_cbe), 64'(e.cbe));
        chk(out_dac == e.dac, "dac", 64'(out_dac), 64'(e.dac));
        chk(out_last == e.last, "last", 64'(out_last), 64'(e.last));
        next_vld = cyc + 2;
        if (e.last) busy = 0;
        have_snap = 0;
        hs_cnt++;
      end else if (out_vld) begin
        snap = cur;
        have_snap = 1;
      end
    end
    if (done) begin
      chk(timeouts == 0, "drive_timeout", 64'(timeouts), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic step(input int k);
    pkt_t p;
    if (in_vld[k] && acc[k]) begin
      in_vld[k] = 1'b0;
      gapc[k] = gap_after[k];
    end
    if (!in_vld[k]) begin
      if (gapc[k] > 0) gapc[k]--;
      else if ((k == 0) ? (cq0.size() != 0) : (cq1.size() != 0)) begin
        p = (k == 0) ? cq0.pop_front() : cq1.pop_front();
        in_addr[k*64 +: 64] = p.addr;
        in_len[k*8 +: 8] = p.len;
        in_id[k*4 +: 4] = p.id;
        gap_after[k] = p.gap;
        in_vld[k] = 1'b1;
      end
    end
  endtask

  // Runs maxcyc cycles, or until all queued work drained when drain is set.
  task automatic drive(input int maxcyc, input bit drain);
    int n = 0;
    while (n < maxcyc && (!drain || cq0.size() != 0 || cq1.size() != 0 || in_vld != 2'b00 ||
                          busy || exp_q.size() != 0)) begin
      @(posedge clk); #1;
      step(0);
      step(1);
      if (rdy_rand) out_rdy = ($urandom_range(0, 3) != 0);
      n++;
    end
    if (drain && n >= maxcyc) timeouts++;
  endtask

  function automatic pkt_t rnd_pkt();
    pkt_t p;
    case ($urandom_range(0, 3))
      0: p.addr = {32'h0, $urandom};
      1: p.addr = {$urandom, 20'($urandom), 12'hF00 | 12'($urandom_range(0, 255))};
      2: p.addr = {$urandom, $urandom};
      default: p.addr = 64'hFFFF_FFFF_FFFF_F000 | 64'($urandom_range(0, 4095));
    endcase
    p.len = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
    p.id = 4'($urandom);
    p.gap = $urandom_range(0, 3);
    return p;
  endfunction

  initial begin
    int n, base;
    logic [7:0] cls [6];
    cls = '{8'd8, 8'd0, 8'd4, 8'd16, 8'd3, 8'd1};
    rst = 1'b1; in_vld = 2'b11; in_addr = '0; in_len = '0; in_id = '0;
    out_rdy = 1'b0; cl_size = 8'd8; gapc = '{0, 0}; gap_after = '{0, 0};
    repeat (3) @(posedge clk);
    #1 in_vld = 2'b00;
    @(posedge clk); #1 rst = 1'b0;
    out_rdy = 1'b1;
    // Directed: aligned MRM read, boundary-split read, 4-way write split, alternating grants
    cq1.push_back('{64'h1000, 8'd15, 4'd1, 0});
    drive(200, 1);
    cq1.push_back('{64'h1FF0, 8'd7, 4'd2, 0});
    drive(200, 1);
    cq0.push_back('{64'h0, 8'd255, 4'd3, 0});
    drive(300, 1);
    for (int i = 0; i < 2; i++) begin
      cq0.push_back('{64'h40 * 64'(i), 8'd0, 4'(4 + i), 0});
      cq1.push_back('{64'h80 * 64'(i), 8'd0, 4'(8 + i), 0});
    end
    drive(300, 1);
    // 64-bit address stalled for 10 cycles
    out_rdy = 1'b0;
    cq1.push_back('{64'h1_0000_0000, 8'd0, 4'd6, 0});
    drive(14, 0);
    out_rdy = 1'b1;
    drive(100, 1);
    // Reset while sub-burst 2 of a write is stalled
    base = hs_cnt;
    cq0.push_back('{64'h0, 8'd255, 4'd5, 0});
    n = 0;
    while (hs_cnt == base && n < 50) begin drive(1, 0); n++; end
    if (n >= 50) timeouts++;
    out_rdy = 1'b0;
    n = 0;
    while (!out_vld && n < 10) begin drive(1, 0); n++; end
    drive(2, 0);
    rst = 1'b1;
    drive(2, 0);
    rst = 1'b0;
    cq0.push_back('{64'h2000, 8'd1, 4'd7, 0});
    cq1.push_back('{64'h3000, 8'd1, 4'd8, 0});
    out_rdy = 1'b1;
    drive(300, 1);
    // Random traffic with random backpressure, one cacheline size per round
    rdy_rand = 1;
    for (int r = 0; r < 6; r++) begin
      cl_size = cls[r];
      for (int i = 0; i < 12; i++) begin
        cq0.push_back(rnd_pkt());
        cq1.push_back(rnd_pkt());
      end
      drive(8000, 1);
    end
    done = 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
